// File: rtl/tile_loop_sequencer_if.sv
// Handshake and configuration bundle for tile_loop_sequencer.
//   master : layer controller / consumer side (drives start, abort, cfg_*,
//            out_ready; observes the beat stream and status)
//   slave  : the sequencer itself
// Signals:
//   start, abort          tile control
//   cfg_rows/cols/depth   loop bounds, latched on an accepted start
//   out_valid/out_ready   beat handshake
//   row_idx/col_idx/k_idx current loop indices
//   first_k/last_k        accumulator clear / write-back markers
//   busy, done            status
interface tile_loop_sequencer_if #(
  parameter int DIM_W = 8
);
  logic             start;
  logic             abort;
  logic [DIM_W-1:0] cfg_rows;
  logic [DIM_W-1:0] cfg_cols;
  logic [DIM_W-1:0] cfg_depth;
  logic             out_ready;
  logic             out_valid;
  logic [DIM_W-1:0] row_idx;
  logic [DIM_W-1:0] col_idx;
  logic [DIM_W-1:0] k_idx;
  logic             first_k;
  logic             last_k;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, cfg_rows, cfg_cols, cfg_depth, out_ready,
    input  out_valid, row_idx, col_idx, k_idx, first_k, last_k, busy, done
  );

  modport slave (
    input  start, abort, cfg_rows, cfg_cols, cfg_depth, out_ready,
    output out_valid, row_idx, col_idx, k_idx, first_k, last_k, busy, done
  );
endinterface

// File: rtl/tile_loop_sequencer.sv
// Nested-loop index generator for one matrix-multiply tile (rows x cols x
// depth). Emits (row, col, k) beats under valid/ready, k innermost, with
// first_k/last_k markers for the MAC accumulators.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   io   tile_loop_sequencer_if.slave (control, config, beat stream, status)
module tile_loop_sequencer #(
  parameter int DIM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tile_loop_sequencer_if.slave  io
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DIM_W-1:0] IDX_ZERO = '0;
  localparam logic [DIM_W-1:0] IDX_ONE  = DIM_W'(1);

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bounds are stored as (bound - 1) so the wrap tests are plain equality
  // compares and never need a counter wider than DIM_W.
  logic [DIM_W-1:0] rows_m1_q, rows_m1_d;
  logic [DIM_W-1:0] cols_m1_q, cols_m1_d;
  logic [DIM_W-1:0] depth_m1_q, depth_m1_d;

  logic k_wrap, col_wrap, row_wrap, last_beat, xfer, accept, zero_bound;

  assign k_wrap     = (k_q == depth_m1_q);
  assign col_wrap   = (col_q == cols_m1_q);
  assign row_wrap   = (row_q == rows_m1_q);
  assign last_beat  = k_wrap && col_wrap && row_wrap;
  assign xfer       = out_valid_q && io.out_ready;
  assign accept     = (state_q == ST_IDLE) && io.start && !io.abort;
  assign zero_bound = (io.cfg_rows == IDX_ZERO) || (io.cfg_cols == IDX_ZERO) ||
                      (io.cfg_depth == IDX_ZERO);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rows_m1_d   = rows_m1_q;
    cols_m1_d   = cols_m1_q;
    depth_m1_d  = depth_m1_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rows_m1_d  = io.cfg_rows - IDX_ONE;
          cols_m1_d  = io.cfg_cols - IDX_ONE;
          depth_m1_d = io.cfg_depth - IDX_ONE;
          row_d      = IDX_ZERO;
          col_d      = IDX_ZERO;
          k_d        = IDX_ZERO;
          busy_d     = 1'b1;
          if (zero_bound) begin
            // Empty tile: report completion without issuing any beat.
            state_d     = ST_DONE;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_RUN;
            out_valid_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (xfer) begin
          if (last_beat) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            row_d       = IDX_ZERO;
            col_d       = IDX_ZERO;
            k_d         = IDX_ZERO;
          end else begin
            k_d = k_wrap ? IDX_ZERO : k_q + IDX_ONE;
            if (k_wrap) begin
              col_d = col_wrap ? IDX_ZERO : col_q + IDX_ONE;
              if (col_wrap) begin
                row_d = row_q + IDX_ONE;
              end
            end
          end
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        row_d       = IDX_ZERO;
        col_d       = IDX_ZERO;
        k_d         = IDX_ZERO;
      end

      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        row_d       = IDX_ZERO;
        col_d       = IDX_ZERO;
        k_d         = IDX_ZERO;
      end
    endcase

    // Abort wins over everything; the beat shown this cycle may still have
    // transferred, but nothing further is issued and no done pulse follows.
    if (io.abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      row_d       = IDX_ZERO;
      col_d       = IDX_ZERO;
      k_d         = IDX_ZERO;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Latched bounds are only meaningful after an accepted start, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    rows_m1_q  <= rows_m1_d;
    cols_m1_q  <= cols_m1_d;
    depth_m1_q <= depth_m1_d;
  end

  assign io.out_valid = out_valid_q;
  assign io.row_idx   = row_q;
  assign io.col_idx   = col_q;
  assign io.k_idx     = k_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.first_k   = out_valid_q && (k_q == IDX_ZERO);
  assign io.last_k    = out_valid_q && k_wrap;

endmodule

// File: tb/tb_tile_loop_sequencer.sv
module tb_tile_loop_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_loop_sequencer_if #(.DIM_W(8)) bus ();

  tile_loop_sequencer #(.DIM_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] k;
    logic       f;
    logic       l;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one tile starting from IDLE (called right after a rising edge).
  // stall_idx: beat number (0-based) held with out_ready=0 for stall_len cycles.
  // abort_idx: beat number on which abort is raised (-1 for none).
  // noise: pulse start and scramble cfg_* while the tile is in flight.
  task automatic run_tile(input int r, input int c, input int d, input int stall_idx,
                          input int stall_len, input int abort_idx, input bit noise);
    int n, beats, stall_left, cyc;
    bit got_done, aborted;
    beat_t b, e;
    n = r * c * d;
    sb.delete();
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        for (int kk = 0; kk < d; kk++) begin
          b.r = 8'(i); b.c = 8'(j); b.k = 8'(kk);
          b.f = (kk == 0); b.l = (kk == d - 1);
          sb.push_back(b);
        end
    bus.cfg_rows  = 8'(r);
    bus.cfg_cols  = 8'(c);
    bus.cfg_depth = 8'(d);
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; beats = 0; stall_left = stall_len; got_done = 0; aborted = 0;
    while (!got_done && !aborted && cyc < 3000) begin
      bus.out_ready = !(beats == stall_idx && stall_left > 0);
      if (!bus.out_ready) stall_left--;
      bus.abort = (beats == abort_idx);
      if (noise) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.cfg_rows  = 8'($urandom_range(0, 255));
        bus.cfg_cols  = 8'($urandom_range(0, 255));
        bus.cfg_depth = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      if (bus.done) begin
        got_done = 1;
        chk("done_cycle", cyc, n + 1 + stall_len);
        chk("done_valid_low", bus.out_valid, 0);
        chk("done_busy_high", bus.busy, 1);
      end else if (bus.out_valid) begin
        chk("busy_in_run", bus.busy, 1);
        if (sb.size() == 0) begin
          chk("unexpected_beat", bus.out_valid, 0);
        end else begin
          e = sb[0];
          chk("row_idx", bus.row_idx, e.r);
          chk("col_idx", bus.col_idx, e.c);
          chk("k_idx", bus.k_idx, e.k);
          chk("first_k", bus.first_k, e.f);
          chk("last_k", bus.last_k, e.l);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            beats++;
          end
        end
      end else begin
        chk("run_valid_missing", bus.out_valid, (sb.size() != 0) ? 1 : 0);
      end
      if (bus.abort) aborted = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    if (aborted) begin
      chk("abort_busy", bus.busy, 0);
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_beats", beats, abort_idx + 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("abort_no_done", bus.done, 0);
        chk("abort_stay_idle", bus.busy, 0);
        @(posedge clk); #1;
      end
      sb.delete();
    end else if (!got_done) begin
      chk("timeout", cyc, n + 1 + stall_len);
    end else begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_valid", bus.out_valid, 0);
      chk("beat_count", beats, n);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;
    bus.cfg_rows = '0; bus.cfg_cols = '0; bus.cfg_depth = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_row", bus.row_idx, 0);
    chk("rst_col", bus.col_idx, 0);
    chk("rst_k", bus.k_idx, 0);
    chk("rst_first", bus.first_k, 0);
    chk("rst_last", bus.last_k, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 2x2x3 tile, no stalls
    run_tile(2, 2, 3, -1, 0, -1, 1'b0);
    // Same tile, 3-cycle stall on beat (0,1,1)
    run_tile(2, 2, 3, 4, 3, -1, 1'b0);
    // Zero depth bound
    run_tile(4, 4, 0, -1, 0, -1, 1'b0);
    // Abort on beat (1,0,2) of a 3x3x3 tile, then a fresh tile
    run_tile(3, 3, 3, -1, 0, 11, 1'b0);
    run_tile(2, 1, 2, -1, 0, -1, 1'b0);
    // start/cfg noise during run
    run_tile(2, 2, 3, -1, 0, -1, 1'b1);
    run_tile(3, 2, 2, 2, 2, -1, 1'b1);
    // Wide single-depth row
    run_tile(1, 255, 1, -1, 0, -1, 1'b0);

    // Asynchronous reset in the middle of a tile
    bus.cfg_rows = 8'd3; bus.cfg_cols = 8'd3; bus.cfg_depth = 8'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_row", bus.row_idx, 0);
    chk("arst_col", bus.col_idx, 0);
    chk("arst_k", bus.k_idx, 0);
    chk("arst_first", bus.first_k, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_tile(1, 2, 2, -1, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
